// File: rtl/mcu_multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle MCU controller: states, opcodes, datapath selects.
// Imported by the interface, the wait timer and the controller top.
package mcu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADDI  = 4'b1000;
  localparam logic [3:0] OP_LOAD  = 4'b1001;
  localparam logic [3:0] OP_STORE = 4'b1010;
  localparam logic [3:0] OP_BEQ   = 4'b1011;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_ILL0  = 4'b1101;
  localparam logic [3:0] OP_ILL1  = 4'b1110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_REG = 2'd0;
  localparam logic [1:0] SRCB_ONE = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;

  localparam int WAIT_LIMIT_DEF = 8;

  // R-type ALU ops occupy the lower half of the opcode space
  function automatic logic is_rtype(input logic [3:0] op);
    return ~op[3];
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == OP_ILL0) || (op == OP_ILL1);
  endfunction

endpackage

// File: rtl/mcu_multi_cycle_control_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath/memory side.
// PERF_COUNTER_EN adds the cycle_cnt/instr_cnt signals.
interface mcu_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       mem_read;
  logic       mem_write;
  logic       mem_addr_sel;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic       reg_write;
  logic       wb_sel;
  logic [2:0] state;
  logic       halted;
  logic       bus_err;
  logic       illegal_op;
`ifdef PERF_COUNTER_EN
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;
`endif

  modport master (
    input  opcode, zero, mem_ready,
    output ir_write, pc_write, pc_src, mem_read, mem_write, mem_addr_sel,
           alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
           state, halted, bus_err, illegal_op
`ifdef PERF_COUNTER_EN
    , output cycle_cnt, instr_cnt
`endif
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  ir_write, pc_write, pc_src, mem_read, mem_write, mem_addr_sel,
           alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
           state, halted, bus_err, illegal_op
`ifdef PERF_COUNTER_EN
    , input cycle_cnt, instr_cnt
`endif
  );
endinterface

// File: rtl/mcu_multi_cycle_control_mem_wait_timer.sv
// Counts consecutive stalled memory cycles; flags a timeout on the WAIT_LIMIT-th stall
// and keeps a sticky bus error until clear.
module mcu_mem_wait_timer #(
  parameter int WAIT_LIMIT = 8
) (
  input  logic clk,
  input  logic clear,
  input  logic i_active,
  input  logic i_mem_ready,
  output logic o_timeout,
  output logic o_bus_err
);
  localparam int W = $clog2(WAIT_LIMIT + 1);

  logic [W-1:0] r_cnt;
  logic         r_bus_err;
  logic         w_stall;

  assign w_stall   = i_active & ~i_mem_ready;
  // r_cnt holds completed stalls, so this cycle is stall number r_cnt+1
  assign o_timeout = w_stall & (r_cnt == W'(WAIT_LIMIT - 1));
  assign o_bus_err = r_bus_err;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_stall && !o_timeout) r_cnt <= r_cnt + 1'b1;
      else                       r_cnt <= '0;
      if (o_timeout) r_bus_err <= 1'b1;
    end
  end
endmodule

// File: rtl/mcu_multi_cycle_control.sv
// Multi-cycle MCU control FSM: sequences fetch/decode/exec/mem/writeback over a shared datapath.
// Optional PERF_COUNTER_EN adds cycle and retired-instruction counters.
//
//   state  | meaning
//   FETCH  | read instruction at PC; on ready load IR and PC+1
//   DECODE | compute branch target; JMP/HALT/illegal resolved here
//   EXEC   | ALU op, address calc, or BEQ compare
//   MEM    | data access at ALUOut
//   WB     | register file write from ALUOut or MDR
//   HALT   | stopped until clear
module mcu_multi_cycle_control
  import mcu_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
`ifdef PERF_COUNTER_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       clear,
  mcu_ctrl_if.master bus
);
  state_t     r_state;
  state_t     w_next;
  logic       w_ir_write;
  logic       w_pc_write;
  logic [1:0] w_pc_src;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_mem_addr_sel;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [3:0] w_alu_op;
  logic       w_reg_write;
  logic       w_wb_sel;
  logic       w_halted;
  logic       w_illegal_op;
  logic       w_timeout;
  logic       w_bus_err;
  logic       w_mem_active;

  assign w_mem_active = (r_state == S_FETCH) || (r_state == S_MEM);

  mcu_mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk         (clk),
    .clear       (clear),
    .i_active    (w_mem_active),
    .i_mem_ready (bus.mem_ready),
    .o_timeout   (w_timeout),
    .o_bus_err   (w_bus_err)
  );

  always_ff @(posedge clk) begin
    if (clear) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    w_ir_write     = 1'b0;
    w_pc_write     = 1'b0;
    w_pc_src       = PC_SRC_SEQ;
    w_mem_read     = 1'b0;
    w_mem_write    = 1'b0;
    w_mem_addr_sel = 1'b0;
    w_alu_src_a    = 1'b0;
    w_alu_src_b    = SRCB_REG;
    w_alu_op       = ALU_ADD;
    w_reg_write    = 1'b0;
    w_wb_sel       = 1'b0;
    w_halted       = 1'b0;
    w_illegal_op   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRCB_ONE;
        if (w_timeout) begin
          w_next = S_HALT;
        end else if (bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        w_alu_src_b = SRCB_IMM;
        if (bus.opcode == OP_JMP) begin
          w_pc_write = 1'b1;
          w_pc_src   = PC_SRC_JUMP;
          w_next     = S_FETCH;
        end else if (bus.opcode == OP_HALT) begin
          w_next = S_HALT;
        end else if (is_illegal(bus.opcode)) begin
          w_illegal_op = 1'b1;
          w_next       = S_FETCH;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_alu_src_a = 1'b1;
        if (is_rtype(bus.opcode)) begin
          w_alu_src_b = SRCB_REG;
          w_alu_op    = bus.opcode;
          w_next      = S_WB;
        end else if (bus.opcode == OP_BEQ) begin
          w_alu_src_b = SRCB_REG;
          w_alu_op    = ALU_SUB;
          w_pc_src    = PC_SRC_BRANCH;
          w_pc_write  = bus.zero;
          w_next      = S_FETCH;
        end else begin
          w_alu_src_b = SRCB_IMM;
          w_next      = (bus.opcode == OP_ADDI) ? S_WB : S_MEM;
        end
      end
      S_MEM: begin
        w_mem_addr_sel = 1'b1;
        w_mem_read     = (bus.opcode == OP_LOAD);
        w_mem_write    = (bus.opcode == OP_STORE);
        if (w_timeout)          w_next = S_HALT;
        else if (bus.mem_ready) w_next = (bus.opcode == OP_LOAD) ? S_WB : S_FETCH;
      end
      S_WB: begin
        w_reg_write = 1'b1;
        w_wb_sel    = (bus.opcode == OP_LOAD);
        w_next      = S_FETCH;
      end
      S_HALT: begin
        w_halted = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // clear overrides everything so an in-flight access cannot commit
  assign bus.ir_write     = ~clear & w_ir_write;
  assign bus.pc_write     = ~clear & w_pc_write;
  assign bus.pc_src       = clear ? 2'd0 : w_pc_src;
  assign bus.mem_read     = ~clear & w_mem_read;
  assign bus.mem_write    = ~clear & w_mem_write;
  assign bus.mem_addr_sel = ~clear & w_mem_addr_sel;
  assign bus.alu_src_a    = ~clear & w_alu_src_a;
  assign bus.alu_src_b    = clear ? 2'd0 : w_alu_src_b;
  assign bus.alu_op       = clear ? 4'd0 : w_alu_op;
  assign bus.reg_write    = ~clear & w_reg_write;
  assign bus.wb_sel       = ~clear & w_wb_sel;
  assign bus.state        = clear ? 3'd0 : r_state;
  assign bus.halted       = ~clear & w_halted;
  assign bus.bus_err      = ~clear & w_bus_err;
  assign bus.illegal_op   = ~clear & w_illegal_op;

`ifdef PERF_COUNTER_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instr_cnt;
  logic             w_retire;

  assign w_retire = (r_state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) && (w_next == S_FETCH);

  always_ff @(posedge clk) begin
    if (clear) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (r_state != S_HALT) r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (w_retire)          r_instr_cnt <= r_instr_cnt + 1'b1;
    end
  end

  assign bus.cycle_cnt = clear ? '0 : r_cycle_cnt;
  assign bus.instr_cnt = clear ? '0 : r_instr_cnt;
`endif
endmodule

// File: doc/mcu_multi_cycle_control.md
Name: mcu_multi_cycle_control

Overview:
Moore/Mealy control FSM that sequences the 16-bit MCU datapath in multi-cycle form. The PC, IR, ALU, register file and a single shared instruction/data memory port are reused across cycles. The block consumes the IR opcode, the ALU zero flag and a memory-ready handshake, and drives every datapath select and write strobe. It sits beside the datapath inside the multi-cycle MCU top and replaces the single-cycle hard-wired decode.

Parameters:
WAIT_LIMIT, 8, maximum consecutive cycles a memory access may stall before a bus error halts the core.
CNT_W, 16, width of the performance counters (optional feature only).

Ports:
clk  input  1  rising-edge clock
clear  input  1  synchronous active-high reset
opcode  input  4  IR[15:12] of the current instruction
zero  input  1  ALU zero flag (valid in EXEC)
mem_ready  input  1  memory completes the current access this cycle
ir_write  output  1  load IR from mem_rdata
pc_write  output  1  load PC
pc_src  output  2  0=ALU result (PC+1), 1=ALUOut (branch target), 2=jump field, 3=reserved
mem_read  output  1  memory read request
mem_write  output  1  memory write request
mem_addr_sel  output  1  0=PC, 1=ALUOut
alu_src_a  output  1  0=PC, 1=reg A
alu_src_b  output  2  0=reg B, 1=const 1, 2=sign-extended imm
alu_op  output  4  ALU function; ADD=0000, SUB=0001, else opcode pass-through
reg_write  output  1  register file write enable
wb_sel  output  1  0=ALUOut, 1=MDR
state  output  3  current FSM state (debug)
halted  output  1  core stopped
bus_err  output  1  sticky; memory stall exceeded WAIT_LIMIT
illegal_op  output  1  one-cycle pulse on an undefined opcode

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Opcodes: 0000-0111 R-type ALU; 1000 ADDI; 1001 LOAD; 1010 STORE; 1011 BEQ; 1100 JMP; 1111 HALT; 1101 and 1110 illegal.
- Reset: on a clk edge with clear=1, state<=FETCH, bus_err<=0, wait counter<=0. While clear=1, all outputs are forced to 0.
- FETCH:
  - mem_read=1, mem_addr_sel=0, alu_src_a=0, alu_src_b=1, alu_op=ADD.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0 (Mealy), then ->DECODE. Otherwise hold in FETCH.
- DECODE:
  - alu_src_a=0, alu_src_b=2, alu_op=ADD; branch target is latched into ALUOut.
  - JMP: pc_write=1, pc_src=2, ->FETCH.
  - HALT: ->HALT.
  - Illegal opcode: illegal_op=1, ->FETCH (executes as a NOP).
  - All other opcodes: ->EXEC.
- EXEC:
  - R-type: alu_src_a=1, alu_src_b=0, alu_op=opcode, ->WB.
  - ADDI/LOAD/STORE: alu_src_a=1, alu_src_b=2, alu_op=ADD. ADDI ->WB; LOAD/STORE ->MEM.
  - BEQ: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1, pc_write=zero, ->FETCH.
- MEM:
  - mem_addr_sel=1. LOAD drives mem_read=1; STORE drives mem_write=1.
  - On mem_ready: LOAD ->WB, STORE ->FETCH.
- WB: reg_write=1; wb_sel=1 for LOAD, otherwise 0; ->FETCH.
- HALT: all strobes 0, halted=1. Exit only via clear.
- Latency with zero-wait memory, in cycles: JMP 2, BEQ 3, R-type/ADDI/STORE 4, LOAD 5. Each memory wait cycle adds one.
- Wait counter:
  - Increments each FETCH/MEM cycle with mem_ready=0 and resets on mem_ready=1.
  - When the count reaches WAIT_LIMIT with mem_ready still 0: bus_err<=1, ->HALT.
  - mem_ready=1 in the same cycle the limit is reached wins; the access completes normally.
- A clear asserted mid-access abandons the access; no pc_write or reg_write occurs in that cycle.

Optional Feature:
PERF_COUNTER_EN.
- Defined: adds outputs cycle_cnt[CNT_W] and instr_cnt[CNT_W], both 0 on clear.
  - cycle_cnt increments every non-HALT cycle.
  - instr_cnt increments on each transition into FETCH from DECODE/EXEC/MEM/WB.
  - Both wrap at 2^CNT_W.
- Undefined: the ports and logic are absent; everything else is identical.

Decomposition:
- Package mcu_ctrl_pkg: state encodings, opcode constants, alu_op/pc_src/alu_src_b encodings, WAIT_LIMIT default.
- One sub-module, mcu_mem_wait_timer: wait counter and bus_err logic, instantiated once.

Test Plan:
1. clear=1 for 2 cycles, then 0 with opcode=0000 and mem_ready=1 -> state sequence 0,1,2,4,0; reg_write=1 only in cycle 4; pc_write in cycle 1.
2. LOAD, mem_ready low for 2 cycles in MEM -> state 3 held 3 cycles, mem_read=1 throughout, then WB with wb_sel=1.
3. BEQ with zero=1, then zero=0 -> EXEC pc_write=1 with pc_src=1; then pc_write=0; both return to FETCH after 3 cycles.
4. opcode=1111 -> HALT, halted=1. Hold 10 cycles with no strobes; clear=1 returns to FETCH.
5. WAIT_LIMIT=8, mem_ready=0 in FETCH -> bus_err=1 and state=5 after 8 stall cycles. Repeat with mem_ready=1 on cycle 8 -> no error.
6. opcode=1101 -> illegal_op pulse in DECODE, ->FETCH. With PERF_COUNTER_EN, instr_cnt increments by 1.
